// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: per-pin direction/output, synchronised input, masked edge IRQ.
// Optional input debounce filter is built when DEBOUNCE_EN is defined.

module gpio_pin
`ifdef DEBOUNCE_EN
  #(parameter int DB_CYCLES = 4)
`endif
(
  input  logic CLK,
  input  logic RST,
  input  logic pin_in,
  output logic filt,
  output logic prev
);
  logic s1, s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  logic [7:0] cnt;

  // s2 is one bit, so any change in s2 while counting brings it back to filt
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt  <= '0;
      filt <= s2;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  assign filt = s2;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev <= 1'b0;
    else      prev <= filt;
  end
endmodule

module gpio_port_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       ADDR,
  input  logic             WE,
  input  logic             RE,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] PIN_OUT,
  output logic [WIDTH-1:0] PIN_OE,
  output logic             IRQ
);
  typedef enum logic [2:0] {
    A_DIR   = 3'd0,
    A_OUT   = 3'd1,
    A_IN    = 3'd2,
    A_IMASK = 3'd3,
    A_IEDGE = 3'd4,
    A_IFLAG = 3'd5
  } addr_e;

  logic [WIDTH-1:0] dir_q, out_q, imask_q, iedge_q, iflag_q;
  logic [WIDTH-1:0] filt, prev, rise, fall, hit, clr, rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef DEBOUNCE_EN
    gpio_pin #(.DB_CYCLES(DB_CYCLES)) u_pin (
`else
    gpio_pin u_pin (
`endif
      .CLK    (CLK),
      .RST    (RST),
      .pin_in (PIN_IN[i]),
      .filt   (filt[i]),
      .prev   (prev[i])
    );
  end

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;
  assign hit  = ((iedge_q & fall) | (~iedge_q & rise)) & ~dir_q;
  assign clr  = (WE && ADDR == A_IFLAG) ? WDATA : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dir_q   <= '0;
      out_q   <= '0;
      imask_q <= '0;
      iedge_q <= '0;
      iflag_q <= '0;
    end else begin
      if (WE && ADDR == A_DIR)   dir_q   <= WDATA;
      if (WE && ADDR == A_OUT)   out_q   <= WDATA;
      if (WE && ADDR == A_IMASK) imask_q <= WDATA;
      if (WE && ADDR == A_IEDGE) iedge_q <= WDATA;
      // a new hit wins over a simultaneous write-1-to-clear
      iflag_q <= hit | (iflag_q & ~clr);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ADDR)
      A_DIR:   rd_mux = dir_q;
      A_OUT:   rd_mux = out_q;
      A_IN:    rd_mux = filt;
      A_IMASK: rd_mux = imask_q;
      A_IEDGE: rd_mux = iedge_q;
      A_IFLAG: rd_mux = iflag_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)   RDATA <= '0;
    else if (RE) RDATA <= rd_mux;
  end

  assign PIN_OUT = out_q;
  assign PIN_OE  = dir_q;
  assign IRQ     = |(iflag_q & imask_q);
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed table-driven bench for gpio_port_ctrl (WIDTH=8); DEBOUNCE_EN selects the filter tests.

module tb_gpio_port_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] ADDR;
  logic       WE, RE;
  logic [7:0] WDATA, RDATA, PIN_IN, PIN_OUT, PIN_OE;
  logic       IRQ;

  gpio_port_ctrl #(.WIDTH(8), .DB_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WE(WE), .RE(RE), .WDATA(WDATA),
    .RDATA(RDATA), .PIN_IN(PIN_IN), .PIN_OUT(PIN_OUT), .PIN_OE(PIN_OE), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       we, re;
    logic [2:0] addr;
    logic [7:0] wdata, pin;
    logic       chk;
    logic [7:0] rd, oe, out;
    logic       irq;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic we, logic re, logic [2:0] addr, logic [7:0] wdata,
                              logic [7:0] pin, logic chk, logic [7:0] rd, logic [7:0] oe,
                              logic [7:0] out, logic irq);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.pin = pin;
    v.chk = chk; v.rd = rd; v.oe = oe; v.out = out; v.irq = irq;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %02h expected %02h", nm, idx, act, exp);
    end
  endtask

  // entered and left at a negedge: drive, clock, sample 1 unit later
  task automatic apply(input vec_t v, input int idx);
    WE = v.we; RE = v.re; ADDR = v.addr; WDATA = v.wdata; PIN_IN = v.pin;
    @(posedge CLK); #1;
    n_vec++;
    if (v.chk) check("rdata", idx, RDATA, v.rd);
    check("pin_oe", idx, PIN_OE, v.oe);
    check("pin_out", idx, PIN_OUT, v.out);
    check("irq", idx, {7'b0, IRQ}, {7'b0, v.irq});
    @(negedge CLK);
  endtask

  task automatic idle(input logic [7:0] pin, input int n);
    WE = 1'b0; RE = 1'b0; ADDR = 3'd0; WDATA = 8'h00; PIN_IN = pin;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reset(input int idx);
    n_vec++;
    check("rst_rdata", idx, RDATA, 8'h00);
    check("rst_oe", idx, PIN_OE, 8'h00);
    check("rst_out", idx, PIN_OUT, 8'h00);
    check("rst_irq", idx, {7'b0, IRQ}, 8'h00);
  endtask

  initial begin
    RST = 1'b0; WE = 1'b0; RE = 1'b0; ADDR = 3'd0; WDATA = 8'h00;
`ifdef DEBOUNCE_EN
    PIN_IN = 8'h00;
`else
    PIN_IN = 8'hFF;
`endif
    repeat (2) @(negedge CLK);
    check_reset(-1);
    RST = 1'b1;

`ifndef DEBOUNCE_EN
    // we re addr wdata pin chk rd oe out irq
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h00,8'h00,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h00,8'h00,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h00,8'h00,0));
    tbl.push_back(mk(0,1,5,8'h00,8'hFF,1,8'hFF,8'h00,8'h00,0));
    tbl.push_back(mk(0,1,2,8'h00,8'hFF,1,8'hFF,8'h00,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h0F,8'hFF,0,8'h00,8'h0F,8'h00,0));
    tbl.push_back(mk(1,0,1,8'hA5,8'hFF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,1,0,8'h00,8'hFF,1,8'h0F,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,1,1,8'h00,8'hFF,1,8'hA5,8'h0F,8'hA5,0));
    tbl.push_back(mk(1,0,5,8'hFF,8'hFF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,1,5,8'h00,8'hFF,1,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(1,0,3,8'h10,8'hEF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hEF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hEF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFF,0,8'h00,8'h0F,8'hA5,1));
    tbl.push_back(mk(0,1,5,8'h00,8'hFF,1,8'h10,8'h0F,8'hA5,1));
    tbl.push_back(mk(1,0,5,8'h10,8'hFF,0,8'h00,8'h0F,8'hA5,0));
    tbl.push_back(mk(1,0,0,8'h00,8'hFF,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(1,0,4,8'h01,8'hFF,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(1,0,5,8'h01,8'hFE,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(0,1,5,8'h00,8'hFE,1,8'h01,8'h00,8'hA5,0));
    tbl.push_back(mk(1,0,3,8'h01,8'hFE,0,8'h00,8'h00,8'hA5,1));
    tbl.push_back(mk(1,0,3,8'h00,8'hFE,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(1,0,5,8'h01,8'hFE,0,8'h00,8'h00,8'hA5,0));
    tbl.push_back(mk(1,0,0,8'h80,8'hFE,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h7E,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h7E,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,2,8'h00,8'h7E,1,8'h7E,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,5,8'h00,8'h7E,1,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,2,8'h00,8'hFE,1,8'hFE,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,5,8'h00,8'hFE,1,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(1,0,2,8'h00,8'hFE,0,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,2,8'h00,8'hFE,1,8'hFE,8'h80,8'hA5,0));
    tbl.push_back(mk(0,1,6,8'h00,8'hFE,1,8'h00,8'h80,8'hA5,0));
    tbl.push_back(mk(1,1,1,8'h3C,8'hFE,1,8'hA5,8'h80,8'h3C,0));
    tbl.push_back(mk(0,1,1,8'h00,8'hFE,1,8'h3C,8'h80,8'h3C,0));
    tbl.push_back(mk(1,0,7,8'hFF,8'hFE,0,8'h00,8'h80,8'h3C,0));
    tbl.push_back(mk(0,1,4,8'h00,8'hFE,1,8'h01,8'h80,8'h3C,0));
    tbl.push_back(mk(0,1,3,8'h00,8'hFE,1,8'h00,8'h80,8'h3C,0));
    foreach (tbl[i]) apply(tbl[i], i);

    // asynchronous reset mid-operation, pins held at FE
    RST = 1'b0;
    #1;
    check_reset(100);
    @(negedge CLK);
    RST = 1'b1;
    tbl2.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h00,8'h00,0));
    tbl2.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h00,8'h00,0));
    tbl2.push_back(mk(0,0,0,8'h00,8'hFE,0,8'h00,8'h00,8'h00,0));
    tbl2.push_back(mk(0,1,5,8'h00,8'hFE,1,8'hFE,8'h00,8'h00,0));
    tbl2.push_back(mk(1,0,3,8'hFF,8'hFE,0,8'h00,8'h00,8'h00,1));
    tbl2.push_back(mk(1,0,5,8'hFE,8'hFE,0,8'h00,8'h00,8'h00,0));
    foreach (tbl2[i]) apply(tbl2[i], 200 + i);
`else
    apply(mk(1,0,3,8'h02,8'h00,0,8'h00,8'h00,8'h00,0), 300);
    idle(8'h02, 2);
    idle(8'h00, 10);
    apply(mk(0,1,2,8'h00,8'h00,1,8'h00,8'h00,8'h00,0), 301);
    apply(mk(0,1,5,8'h00,8'h00,1,8'h00,8'h00,8'h00,0), 302);
    idle(8'h02, 6);
    idle(8'h00, 3);
    apply(mk(0,1,5,8'h00,8'h00,1,8'h02,8'h00,8'h00,1), 303);
    idle(8'h00, 8);
    apply(mk(0,1,2,8'h00,8'h00,1,8'h00,8'h00,8'h00,1), 304);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
